// File: rtl/sseg_serial_rx_pkg.sv
// Shared constants for the 7-segment serial display link receiver.
// Frame size, synchronizer depth and counter width match the SSeg7_Dev link.
package sseg_serial_rx_pkg;
  localparam int SSEG_FRAME_BITS  = 64;
  localparam int SSEG_SYNC_STAGES = 2;
  localparam int SSEG_CNT_W       = 7;
  localparam logic SSEG_CLRN_IDLE = 1'b1;
  localparam logic SSEG_MSB_FIRST = 1'b1;
endpackage

// File: rtl/sseg_serial_rx_sync_edge.sv
// Flop-chain synchronizer for one link wire, with edge detection
// against one history flop behind the last sync stage.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      hist <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      hist <= sync[STAGES-1];
    end
  end

  assign lvl  = sync[STAGES-1];
  assign rise = lvl & ~hist;
  assign fall = ~lvl & hist;
endmodule

// File: rtl/sseg_serial_rx.sv
// Receiver for the 7-segment serial link: rebuilds the shifted frame,
// latches it on the parallel-enable edge and flags wrong bit counts.
module sseg_serial_rx
  import sseg_serial_rx_pkg::*;
#(
  parameter int FRAME_BITS  = SSEG_FRAME_BITS,
  parameter int SYNC_STAGES = SSEG_SYNC_STAGES,
  parameter int CNT_W       = SSEG_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seg_clk,
  input  logic                  seg_sout,
  input  logic                  SEG_PEN,
  input  logic                  seg_clrn,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      bit_cnt
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic clk_lvl, clk_rise, clk_fall;
  logic sout_lvl, sout_rise, sout_fall;
  logic pen_lvl, pen_rise, pen_fall;
  logic clrn_lvl, clrn_rise, clrn_fall;
  logic unused_edges;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk (
    .clk(clk), .rst(rst), .din(seg_clk),
    .lvl(clk_lvl), .rise(clk_rise), .fall(clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sout (
    .clk(clk), .rst(rst), .din(seg_sout),
    .lvl(sout_lvl), .rise(sout_rise), .fall(sout_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_pen (
    .clk(clk), .rst(rst), .din(SEG_PEN),
    .lvl(pen_lvl), .rise(pen_rise), .fall(pen_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SSEG_CLRN_IDLE)) u_clrn (
    .clk(clk), .rst(rst), .din(seg_clrn),
    .lvl(clrn_lvl), .rise(clrn_rise), .fall(clrn_fall)
  );

  assign unused_edges = &{clk_lvl, clk_fall, sout_rise, sout_fall,
                          pen_lvl, pen_fall, clrn_rise, clrn_fall};

  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] sh_next;
  logic [CNT_W-1:0]      cnt_next;

  // Shift is resolved first so a coincident latch sees the new bit.
  always_comb begin
    sh_next  = shreg;
    cnt_next = bit_cnt;
    if (!clrn_lvl) begin
      sh_next  = '0;
      cnt_next = '0;
    end else if (clk_rise) begin
      sh_next  = {shreg[FRAME_BITS-2:0], sout_lvl};
      cnt_next = (bit_cnt >= CNT_MAX) ? CNT_MAX : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg       <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      shreg       <= sh_next;
      frame_valid <= pen_rise;
      if (pen_rise) begin
        frame     <= sh_next;
        frame_err <= (cnt_next != CNT_FULL);
        bit_cnt   <= '0;
      end else begin
        bit_cnt   <= cnt_next;
      end
    end
  end
endmodule

// File: tb/tb_sseg_serial_rx.sv
// Bench for sseg_serial_rx: table-driven frames, link corner cases,
// and random frames checked against a bit-queue model of the chain.
module tb_sseg_serial_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic        seg_clk;
  logic        seg_sout;
  logic        SEG_PEN;
  logic        seg_clrn;
  logic [63:0] frame;
  logic        frame_valid;
  logic        frame_err;
  logic [6:0]  bit_cnt;

  sseg_serial_rx dut (
    .clk(clk), .rst(rst),
    .seg_clk(seg_clk), .seg_sout(seg_sout),
    .SEG_PEN(SEG_PEN), .seg_clrn(seg_clrn),
    .frame(frame), .frame_valid(frame_valid),
    .frame_err(frame_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int           n;
    logic [127:0] d;
    logic [63:0]  f;
    logic         e;
    logic [6:0]   cnt;
  } vec_t;

  vec_t tv[4];
  bit   q[$];

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(bit b);
    seg_sout = b;
    tick(3);
    seg_clk = 1'b1;
    tick(3);
    seg_clk = 1'b0;
  endtask

  task automatic send_bits(logic [127:0] d, int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
    tick(4);
  endtask

  // PEN rise (optionally with a coincident seg_clk rise), held high
  // for 10 cycles: expect one valid pulse, 3 cycles after the pin edge.
  task automatic pen(string name, bit with_clk);
    int lat;
    int nv;
    lat = -1;
    nv  = 0;
    SEG_PEN = 1'b1;
    if (with_clk) seg_clk = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (frame_valid) begin
        nv++;
        if (lat < 0) lat = i;
      end
    end
    @(negedge clk);
    SEG_PEN = 1'b0;
    seg_clk = 1'b0;
    tick(4);
    check({name, " latency"}, 64'(lat), 64'd3);
    check({name, " pulses"}, 64'(nv), 64'd1);
  endtask

  task automatic check_latch(string name, logic [63:0] f, logic e);
    check({name, " frame"}, frame, f);
    check({name, " err"}, {63'd0, frame_err}, {63'd0, e});
    check({name, " cnt0"}, {57'd0, bit_cnt}, 64'd0);
  endtask

  initial begin
    logic [63:0] exp_f;
    logic [63:0] rnd;
    int          n;
    int          idx;

    rst = 1'b1; seg_clk = 1'b0; seg_sout = 1'b0;
    SEG_PEN = 1'b0; seg_clrn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset frame", frame, 64'd0);
    check("reset valid", {63'd0, frame_valid}, 64'd0);
    check("reset err", {63'd0, frame_err}, 64'd0);
    check("reset cnt", {57'd0, bit_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);

    tv[0] = '{64, 128'hDEADBEEF01234567,
              64'hDEADBEEF01234567, 1'b0, 7'd64};
    tv[1] = '{63, 128'h0,
              64'h8000000000000000, 1'b1, 7'd63};
    tv[2] = '{70, 128'h3F_FFFF_FFFF_FFFF_FFC0,
              64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 7'd65};
    tv[3] = '{64, 128'hA5A5A5A5A5A5A5A5,
              64'hA5A5A5A5A5A5A5A5, 1'b0, 7'd64};

    for (int k = 0; k < 4; k++) begin
      send_bits(tv[k].d, tv[k].n);
      check($sformatf("tv%0d cnt", k), {57'd0, bit_cnt},
            {57'd0, tv[k].cnt});
      pen($sformatf("tv%0d", k), 1'b0);
      check_latch($sformatf("tv%0d", k), tv[k].f, tv[k].e);
    end

    pen("zero", 1'b0);
    check_latch("zero", 64'hA5A5A5A5A5A5A5A5, 1'b1);

    send_bits(128'hFFFFF, 20);
    seg_clrn = 1'b0;
    tick(4);
    check("clr hold frame", frame, 64'hA5A5A5A5A5A5A5A5);
    check("clr cnt", {57'd0, bit_cnt}, 64'd0);
    send_bits(128'h1F, 5);
    check("clr ignore", {57'd0, bit_cnt}, 64'd0);
    seg_clrn = 1'b1;
    tick(4);
    send_bits(128'hA5A5A5A5A5A5A5A5, 64);
    pen("clr rel", 1'b0);
    check_latch("clr rel", 64'hA5A5A5A5A5A5A5A5, 1'b0);

    send_bits(128'h3, 2);
    seg_clrn = 1'b0;
    tick(4);
    pen("clr pen", 1'b0);
    check_latch("clr pen", 64'd0, 1'b1);
    seg_clrn = 1'b1;
    tick(4);

    send_bits(128'h0123456789ABCDEF >> 1, 63);
    seg_sout = 1'b1;
    tick(3);
    pen("simul", 1'b1);
    check_latch("simul", 64'h0123456789ABCDEF, 1'b0);

    send_bits(128'hFFFFFFFF, 32);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst frame", frame, 64'd0);
    check("rst cnt", {57'd0, bit_cnt}, 64'd0);
    check("rst flags", {62'd0, frame_valid, frame_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(4);
    pen("post rst", 1'b0);
    check_latch("post rst", 64'd0, 1'b1);

    q.delete();
    for (int k = 0; k < 8; k++) begin
      n = (k % 2 == 0) ? 64 : int'($urandom_range(60, 68));
      rnd = {$urandom, $urandom};
      for (int i = n - 1; i >= 0; i--) begin
        q.push_back(i < 64 ? rnd[i] : 1'b1);
        send_bit(i < 64 ? rnd[i] : 1'b1);
      end
      tick(4);
      check($sformatf("rnd%0d cnt", k), {57'd0, bit_cnt},
            64'(n > 65 ? 65 : n));
      exp_f = '0;
      for (int i = 0; i < 64; i++) begin
        idx = q.size() - 1 - i;
        if (idx >= 0) exp_f[i] = q[idx];
      end
      pen($sformatf("rnd%0d", k), 1'b0);
      check_latch($sformatf("rnd%0d", k), exp_f, n != 64);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
